rr_encoder_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among 8 requesters.
//  - Built around an 8-to-3 priority encoder: a rotating mask gives fair access.
//  - One-hot grant is held until the owner releases the resource.
//  - Sits in front of any shared datapath; gnt_id drives that datapath's select mux.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_prio_enc.sv | 45 ++++
 rtl/rr_encoder_arbiter.sv | 118 +++++++++++
 tb/tb_rr_encoder_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin encoder arbiter.
// Grant-vector helper maps a binary owner index to its one-hot grant.
package arb_pkg;

    localparam int unsigned N_DEF        = 8;
    localparam int unsigned W_DEF        = 3;
    localparam int unsigned MAX_HOLD_DEF = 16;

    typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

    function automatic logic [N_DEF-1:0] onehot(input logic [W_DEF-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating-mask priority encoder: lowest set bit above ptr wins,
// falling back to the lowest set bit overall when nothing lies above ptr.
module rr_prio_enc
    import arb_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] masked;
    logic [W-1:0] idx_masked;
    logic [W-1:0] idx_full;
    logic         any_masked;
    logic         any_full;

    always_comb begin
        masked     = '0;
        idx_masked = '0;
        idx_full   = '0;
        any_masked = 1'b0;
        any_full   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            masked[i] = vec[i] && (W'(i) > ptr);
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (masked[i] && !any_masked) begin
                idx_masked = W'(i);
                any_masked = 1'b1;
            end
            if (vec[i] && !any_full) begin
                idx_full = W'(i);
                any_full = 1'b1;
            end
        end
    end

    assign idx = any_masked ? idx_masked : idx_full;
    assign any = any_full;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter: one-hot grant held until done or the owner drops its request.
// Optional grant watchdog is built when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned W = W_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id,
    output logic         gnt_valid,
    output logic         timeout
);

    arb_state_t   state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [W-1:0] id_q, id_d;
    logic [W-1:0] last_q, last_d;
    logic         valid_q, valid_d;
    logic [W-1:0] win_idx;
    logic         win_any;
    logic         rel;
    logic         revoke;

    rr_prio_enc #(
        .N (N),
        .W (W)
    ) u_enc (
        .vec (req),
        .ptr (last_q),
        .idx (win_idx),
        .any (win_any)
    );

    assign rel = done || !req[id_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [CW-1:0] hold_q, hold_d;
    logic          timeout_q;

    // Counter restarts on every IDLE cycle, so it reads 0 in the first grant cycle.
    assign hold_d = (state_q == ST_GRANT) ? hold_q + 1'b1 : '0;
    assign revoke = (state_q == ST_GRANT) && (hold_q == CW'(MAX_HOLD - 1)) && !rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= revoke;
        end
    end

    assign timeout = timeout_q;
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    gnt_d   = onehot(win_idx);
                    id_d    = win_idx;
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel || revoke) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= W'(N - 1);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter; the watchdog section follows ARB_TIMEOUT_EN.
module tb_rr_encoder_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;

    rr_encoder_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_id", 32'(gnt_id), 32'd0);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        step();
        rst_n = 1'b1;

        // Single requester 3
        req = 8'h08;
        step();
        chk("t1_gnt", 32'(gnt), 32'h08);
        chk("t1_id", 32'(gnt_id), 32'd3);
        chk("t1_valid", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        step();
        chk("t1_rel_valid", 32'(gnt_valid), 32'd0);
        chk("t1_id_hold", 32'(gnt_id), 32'd3);

        // Requesters 0 and 7 after reset
        do_reset();
        req = 8'h81;
        step();
        chk("t2_id0", 32'(gnt_id), 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t2_gap_gnt", 32'(gnt), 32'h00);
        step();
        chk("t2_gnt7", 32'(gnt), 32'h80);
        chk("t2_id7", 32'(gnt_id), 32'd7);
        req = 8'h00;
        step();

        // All requesting: full rotation 0..7 then back to 0
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("t3_id_%0d", k), 32'(gnt_id), 32'(k % 8));
            done = 1'b1;
            step();
            done = 1'b0;
            chk($sformatf("t3_rel_%0d", k), 32'(gnt_valid), 32'd0);
        end
        req = 8'h00;
        step();

        // Owner 5 drops its request, then 0 wins by wrap-around
        req = 8'h20;
        step();
        chk("t4_id5", 32'(gnt_id), 32'd5);
        req = 8'h01;
        step();
        chk("t4_drop_gnt", 32'(gnt), 32'h00);
        chk("t4_drop_valid", 32'(gnt_valid), 32'd0);
        req = 8'h21;
        step();
        chk("t4_wrap_id", 32'(gnt_id), 32'd0);
        // Non-owner request changes do not disturb the grant
        req = 8'hA1;
        step();
        chk("t4_hold_gnt", 32'(gnt), 32'h01);
        // done with a new request: new request competes in the following IDLE cycle
        done = 1'b1;
        req  = 8'h80;
        step();
        done = 1'b0;
        chk("t4_done_valid", 32'(gnt_valid), 32'd0);
        step();
        chk("t4_new_id", 32'(gnt_id), 32'd7);
        req = 8'h00;
        step();

        // Asynchronous reset mid-grant
        req = 8'h40;
        step();
        chk("t6_id6", 32'(gnt_id), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'h00);
        chk("t6_async_id", 32'(gnt_id), 32'd0);
        chk("t6_async_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h41;
        step();
        chk("t6_after_id", 32'(gnt_id), 32'd0);
        req = 8'h00;
        step();
        step();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: 16 grant cycles, revoke with timeout pulse, then re-grant
        req = 8'h04;
        step();
        chk("t5_first", 32'(gnt), 32'h04);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("t5_held_%0d", k), 32'({gnt_valid, timeout}), 32'b10);
        end
        step();
        chk("t5_revoke_valid", 32'(gnt_valid), 32'd0);
        chk("t5_timeout", 32'(timeout), 32'd1);
        step();
        chk("t5_regrant_id", 32'(gnt_id), 32'd2);
        chk("t5_regrant_valid", 32'(gnt_valid), 32'd1);
        chk("t5_timeout_off", 32'(timeout), 32'd0);
`else
        // Without the watchdog a grant is held indefinitely
        req = 8'h04;
        for (int k = 0; k < 24; k++) step();
        chk("t5_held_gnt", 32'(gnt), 32'h04);
        chk("t5_no_timeout", 32'(timeout), 32'd0);
`endif
        req = 8'h00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
